mux4to1: RTL and testbench

//  - 4-input, 1-output data selector for the TD4 CPU datapath; picks one of four

---
 rtl/mux4to1_pkg.sv | 17 +
 rtl/mux4to1_dec.sv | 13 +
 rtl/mux4to1.sv | 55 +++++
 tb/tb_mux4to1.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mux4to1_pkg.sv
// Shared types and helpers for the TD4 operand-bus 4:1 selector.
// Decoder output is also exported as sel_oh when MUX4TO1_SEL_ONEHOT_EN is defined.
package mux4to1_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_C0 = 2'd0;
    localparam sel_t SEL_C1 = 2'd1;
    localparam sel_t SEL_C2 = 2'd2;
    localparam sel_t SEL_C3 = 2'd3;

    // Shift form keeps an unknown select visible as X instead of masking it.
    function automatic logic [3:0] onehot4(input sel_t s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/mux4to1_dec.sv
// 2-to-4 one-hot select decoder; drives the AND-OR lane gating in mux4to1.
module mux4to1_dec
    import mux4to1_pkg::*;
(
    input  logic [1:0] sel,
    output logic [3:0] oh
);

    always_comb begin
        oh = onehot4(sel_t'(sel));
    end

endmodule

// File: rtl/mux4to1.sv
// 4-lane operand selector with a combinational output and a registered copy.
// Optional registered one-hot select output: define MUX4TO1_SEL_ONEHOT_EN.
module mux4to1
    import mux4to1_pkg::*;
#(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*WIDTH-1:0]   c,
    input  logic [1:0]           sel,
    input  logic                 en,
    output logic [WIDTH-1:0]     y,
    output logic [WIDTH-1:0]     y_q
`ifdef MUX4TO1_SEL_ONEHOT_EN
    ,
    output logic [3:0]           sel_oh
`endif
);

    logic [3:0] oh;

    mux4to1_dec u_dec (
        .sel (sel),
        .oh  (oh)
    );

    // AND-OR structure mirrors the 74HC153 used in the original TD4 board.
    always_comb begin
        y = '0;
        for (int k = 0; k < 4; k++) begin
            y = y | (c[k*WIDTH +: WIDTH] & {WIDTH{oh[k]}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= RESET_VAL;
        end else if (en) begin
            y_q <= y;
        end
    end

`ifdef MUX4TO1_SEL_ONEHOT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_oh <= 4'b0000;
        end else if (en) begin
            sel_oh <= oh;
        end
    end
`endif

endmodule

// File: tb/tb_mux4to1.sv
// Self-checking bench for mux4to1: directed pins plus randomized traffic vs a lane model.
module tb_mux4to1;
    import mux4to1_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  c1;
    logic [15:0] c4;
    logic [1:0]  sel;
    logic        en;
    logic        y1, y1_q;
    logic [3:0]  y4, y4_q;
`ifdef MUX4TO1_SEL_ONEHOT_EN
    logic [3:0]  oh1, oh4;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    // Reference state: what the registered outputs must hold.
    logic       m1_q;
    logic [3:0] m4_q;
    logic [3:0] m_oh;

    always #5 clk = ~clk;

    mux4to1 #(.WIDTH(1)) dut1 (
        .clk (clk), .rst (rst), .c (c1), .sel (sel), .en (en), .y (y1), .y_q (y1_q)
`ifdef MUX4TO1_SEL_ONEHOT_EN
        , .sel_oh (oh1)
`endif
    );

    mux4to1 #(.WIDTH(4)) dut4 (
        .clk (clk), .rst (rst), .c (c4), .sel (sel), .en (en), .y (y4), .y_q (y4_q)
`ifdef MUX4TO1_SEL_ONEHOT_EN
        , .sel_oh (oh4)
`endif
    );

    function automatic logic lane1(input logic [3:0] c, input int s);
        return (c >> s) & 1'b1;
    endfunction

    function automatic logic [3:0] lane4(input logic [15:0] c, input int s);
        return 4'((c >> (4 * s)) & 16'h000F);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_q <= 1'b0;
            m4_q <= 4'h0;
            m_oh <= 4'h0;
        end else if (en) begin
            m1_q <= lane1(c1, int'(sel));
            m4_q <= lane4(c4, int'(sel));
            m_oh <= 4'(1 << sel);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmp y1", 16'(y1), 16'(lane1(c1, int'(sel))));
            check("cmp y4", 16'(y4), 16'(lane4(c4, int'(sel))));
            check("cmp y1_q", 16'(y1_q), 16'(m1_q));
            check("cmp y4_q", 16'(y4_q), 16'(m4_q));
`ifdef MUX4TO1_SEL_ONEHOT_EN
            check("cmp oh1", 16'(oh1), 16'(m_oh));
            check("cmp oh4", 16'(oh4), 16'(m_oh));
`endif
        end
    end

    initial begin
        sel_t sels [4];
        sels[0] = SEL_C0; sels[1] = SEL_C1; sels[2] = SEL_C2; sels[3] = SEL_C3;

        c1 = 4'b0000; c4 = 16'h0000; sel = 2'd0; en = 1'b0;
        #1 rst = 1'b1;
        #7;
        check("reset y", 16'(y1), 16'h0);
        check("reset y_q", 16'(y1_q), 16'h0);
        check("reset y4_q", 16'(y4_q), 16'h0);
`ifdef MUX4TO1_SEL_ONEHOT_EN
        check("reset sel_oh", 16'(oh1), 16'h0);
`endif
        step();
        rst = 1'b0;
        cmp_on = 1'b1;

        // Literal pins on the lane model.
        c1 = 4'b0101;
        sel = 2'd0; #1 check("c0101 sel0", 16'(y1), 16'h1);
        sel = 2'd1; #1 check("c0101 sel1", 16'(y1), 16'h0);
        sel = 2'd2; #1 check("c0101 sel2", 16'(y1), 16'h1);
        sel = 2'd3; #1 check("c0101 sel3", 16'(y1), 16'h0);

        for (int v = 1; v < 16; v++) begin
            for (int s = 0; s < 4; s++) begin
                step();
                c1 = 4'(v);
                c4 = {4{4'(v)}} ^ 16'h1248;
                sel = sels[s];
                #1 check("sweep y", 16'(y1), 16'(lane1(c1, s)));
            end
        end

        step();
        c1 = 4'b1000; sel = 2'd3; en = 1'b1;
        step();
        check("load c1000 sel3", 16'(y1_q), 16'h1);
        en = 1'b0; sel = 2'd0;
        step();
        check("hold en0", 16'(y1_q), 16'h1);

        sel = 2'd3;
        rst = 1'b1;
        #1;
        check("async rst y_q", 16'(y1_q), 16'h0);
        check("async rst y", 16'(y1), 16'h1);
        step();
        rst = 1'b0;

        c4 = 16'hDCBA; sel = 2'd2; en = 1'b1;
        #1 check("w4 y", 16'(y4), 16'hC);
        step();
        check("w4 y_q", 16'(y4_q), 16'hC);
`ifdef MUX4TO1_SEL_ONEHOT_EN
        check("oh sel2", 16'(oh1), 16'h4);
        rst = 1'b1;
        #1 check("oh rst", 16'(oh1), 16'h0);
        step();
        rst = 1'b0;
`endif

        for (int i = 0; i < 400; i++) begin
            step();
            c1  = 4'($urandom);
            c4  = 16'($urandom);
            sel = 2'($urandom);
            en  = 1'($urandom);
            rst = ($urandom_range(0, 15) == 0);
        end
        step();
        rst = 1'b0;
        step();
        cmp_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
